// File: rtl/ysyx_24100005_pkg.sv
// Shared definitions for the ysyx_24100005 fetch front end: FSM encoding,
// data-path width and architectural reset constants.
package ysyx_24100005_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ifu_state_e;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;

endpackage

// File: rtl/ysyx_24100005_Reg.sv
// Generic write-enabled register with synchronous active-high reset.
module ysyx_24100005_Reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);

    logic [WIDTH-1:0] dout_q;

    // State register: reset wins, otherwise load on write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= RESET_VAL;
        end else if (wen) begin
            dout_q <= din;
        end else begin
            dout_q <= dout_q;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one read per instruction
// and presents {inst, pc, fault} to the core over a valid/ready port.
module ysyx_24100005_ifu
    import ysyx_24100005_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_fault,
    input  logic [31:0] next_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic [31:0] fetch_cnt
);

    ifu_state_e        state_q, state_d;
    logic              drop_q, drop_d;
    logic [XLEN-1:0]   out_inst_q, out_inst_d;
    logic [XLEN-1:0]   out_pc_q, out_pc_d;
    logic              out_fault_q, out_fault_d;

    logic [XLEN-1:0]   pc_q, pc_d;
    logic              pc_we;
    logic [XLEN-1:0]   cnt_q;
    logic              cnt_we;

    logic              misaligned;
    logic              req_fire;

    ysyx_24100005_Reg #(.WIDTH(XLEN), .RESET_VAL(RESET_PC)) u_pc (
        .clk  (clk),
        .rst  (rst),
        .din  (pc_d),
        .dout (pc_q),
        .wen  (pc_we)
    );

    ysyx_24100005_Reg #(.WIDTH(XLEN), .RESET_VAL(32'h0000_0000)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .din  (cnt_q + 32'd1),
        .dout (cnt_q),
        .wen  (cnt_we)
    );

    assign misaligned    = (pc_q[1:0] != 2'b00);
    assign mem_req_valid = !rst && (state_q == ST_REQ) && !misaligned;
    assign mem_req_addr  = pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // Next-state, PC update and output-latch selection; flush dominates.
    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        out_fault_d = out_fault_q;
        pc_d        = next_pc;
        pc_we       = 1'b0;
        cnt_we      = 1'b0;
        case (state_q)
            ST_REQ: begin
                if (flush) begin
                    pc_d  = flush_pc;
                    pc_we = 1'b1;
                    if (req_fire) begin
                        // Request already left for the old PC: swallow its response.
                        state_d = ST_WAIT;
                        drop_d  = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else if (misaligned) begin
                    state_d     = ST_HOLD;
                    out_fault_d = 1'b1;
                    out_inst_d  = NOP_INST;
                    out_pc_d    = pc_q;
                end else if (req_fire) begin
                    state_d = ST_WAIT;
                    drop_d  = 1'b0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    pc_d  = flush_pc;
                    pc_we = 1'b1;
                    if (mem_rsp_valid) begin
                        state_d = ST_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (mem_rsp_valid) begin
                    if (drop_q) begin
                        state_d = ST_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        state_d     = ST_HOLD;
                        out_inst_d  = mem_rsp_data;
                        out_pc_d    = pc_q;
                        out_fault_d = mem_rsp_err;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    pc_we   = 1'b1;
                    state_d = ST_REQ;
                end else if (out_ready) begin
                    pc_d    = next_pc;
                    pc_we   = 1'b1;
                    cnt_we  = 1'b1;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_REQ;
                drop_d  = 1'b0;
            end
        endcase
    end

    // FSM and output holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_REQ;
            drop_q      <= 1'b0;
            out_inst_q  <= 32'h0000_0000;
            out_pc_q    <= 32'h0000_0000;
            out_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            out_fault_q <= out_fault_d;
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign out_inst  = out_inst_q;
    assign out_pc    = out_pc_q;
    assign out_fault = out_fault_q;
    assign fetch_cnt = cnt_q;

endmodule
